// File: rtl/sram_fifo_ctrl.sv
// FIFO controller that uses a single-port synchronous SRAM as storage.
// The SRAM's registered read data doubles as the one-word output stage.
module sram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sram_cs,
  output logic              sram_we,
  output logic              sram_rd,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE = (ADDR_W)'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   mem_count_q, mem_count_d;
  logic              out_valid_q, out_valid_d;

  logic rd_req;
  logic wr_fire;

  // A read refills the output stage whenever it is empty or being consumed;
  // it always wins the single SRAM port over a pending write.
  assign rd_req   = (mem_count_q != '0) && (!out_valid_q || out_ready);
  assign full     = (mem_count_q == DEPTH_CNT);
  assign in_ready = !rst && !full && !rd_req;
  assign wr_fire  = in_valid && in_ready;

  assign sram_rd    = rd_req;
  assign sram_we    = wr_fire;
  assign sram_cs    = sram_rd | sram_we;
  assign sram_addr  = rd_req ? rd_ptr_q : wr_ptr_q;
  assign sram_wdata = in_data;

  assign out_data  = sram_rdata;
  assign out_valid = out_valid_q;
  assign level     = mem_count_q + {{ADDR_W{1'b0}}, out_valid_q};
  assign empty     = (level == '0);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    if (wr_fire) begin
      wr_ptr_d    = wr_ptr_q + PTR_ONE;
      mem_count_d = mem_count_q + CNT_ONE;
    end else if (rd_req) begin
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      mem_count_d = mem_count_q - CNT_ONE;
    end
    if (rd_req) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl: behavioural SRAM plus a queue-based
// reference model of FIFO contents, occupancy and address sequencing.
module tb_sram_fifo_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              sram_cs, sram_we, sram_rd;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata, sram_rdata;
  logic [ADDR_W:0]   level;
  logic              full, empty;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] mem [DEPTH];

  sram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_rd(sram_rd),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .level(level), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Single-port synchronous SRAM with held, registered read data.
  always @(posedge clk) begin
    if (sram_cs && sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_cs && sram_rd) sram_rdata <= mem[sram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 8'hA5;
    tick(); #1;
    n_checks++; if (sram_cs !== 1'b0) begin n_fail++; $display("FAIL reset_cs got=%b exp=0", sram_cs); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_checks++; if (level !== 9'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
    n_checks++; if (full !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL reset_flags got full=%b empty=%b exp full=0 empty=1", full, empty); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0; #1;
    n_checks++; if (level !== 9'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL post_reset_level got=%0d empty=%b exp 0/1", level, empty); end
    tick();
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] words [5];
    bit ok;
    words = '{8'h00, 8'h01, 8'h10, 8'h06, 8'h12};
    do_reset();
    in_valid = 1'b1; in_data = words[0]; #1;
    n_checks++; if (in_ready !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 8'd0) begin n_fail++; $display("FAIL basic_first_write got ready=%b we=%b addr=%0d exp 1/1/0", in_ready, sram_we, sram_addr); end
    tick();
    in_data = words[1]; #1;
    n_checks++; if (sram_rd !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 8'd0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_first_read got rd=%b we=%b addr=%0d ready=%b exp 1/0/0/0", sram_rd, sram_we, sram_addr, in_ready); end
    tick(); #1;
    n_checks++; if (out_valid !== 1'b1 || out_data !== words[0]) begin n_fail++; $display("FAIL basic_first_out got valid=%b data=%h exp 1/%h", out_valid, out_data, words[0]); end
    for (int w = 1; w < 5; w++) begin
      in_valid = 1'b1; in_data = words[w]; ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
        #1;
        if (in_ready) ok = 1'b1;
        tick();
      end
      n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_push_timeout word=%0d got no accept exp accept", w); end
    end
    in_valid = 1'b0; #1;
    n_checks++; if (level !== 9'd5) begin n_fail++; $display("FAIL basic_level got=%0d exp=5", level); end
    out_ready = 1'b1;
    for (int w = 0; w < 5; w++) begin
      #1;
      n_checks++; if (out_valid !== 1'b1 || out_data !== words[w]) begin n_fail++; $display("FAIL basic_pop%0d got valid=%b data=%h exp 1/%h", w, out_valid, out_data, words[w]); end
      tick();
    end
    #1;
    n_checks++; if (empty !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained got empty=%b valid=%b exp 1/0", empty, out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_full();
    logic [DATA_W-1:0] q [$];
    int accepted = 0;
    bit ok = 1'b0;
    do_reset();
    in_valid = 1'b1;
    for (int c = 0; c < 400; c++) begin
      in_data = DATA_W'($urandom); #1;
      if (in_ready) begin accepted++; q.push_back(in_data); end
      tick();
    end
    #1;
    n_checks++; if (accepted !== 257) begin n_fail++; $display("FAIL full_accepted got=%0d exp=257", accepted); end
    n_checks++; if (full !== 1'b1 || in_ready !== 1'b0 || level !== 9'd257) begin n_fail++; $display("FAIL full_state got full=%b ready=%b level=%0d exp 1/0/257", full, in_ready, level); end
    n_checks++; if (out_data !== q[0]) begin n_fail++; $display("FAIL full_head got=%h exp=%h", out_data, q[0]); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; void'(q.pop_front());
    for (int c = 0; c < 4 && !ok; c++) begin
      #1;
      if (in_ready) ok = 1'b1; else tick();
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL full_ready_return got ready=0 exp ready=1"); end
    in_valid = 1'b0; #1;
    n_checks++; if (level !== 9'd256 || out_data !== q[0]) begin n_fail++; $display("FAIL full_after_pop got level=%0d data=%h exp 256/%h", level, out_data, q[0]); end
    tick();
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] q [$];
    int sent = 0, recv = 0, wr_n = 0, rd_n = 0, max_level = 0;
    logic [DATA_W-1:0] exp_d;
    do_reset();
    for (int c = 0; c < 20000 && recv < 600; c++) begin
      in_valid  = (sent < 600) && ($urandom_range(1) == 1);
      in_data   = DATA_W'($urandom);
      out_ready = ($urandom_range(1) == 1);
      #1;
      if (int'(level) > max_level) max_level = int'(level);
      n_checks++; if (int'(level) !== q.size()) begin n_fail++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", c, level, q.size()); end
      n_checks++; if ((sram_rd && sram_we) || sram_cs !== (sram_rd | sram_we) || sram_we !== (in_valid && in_ready)) begin n_fail++; $display("FAIL rnd_strobes cyc=%0d got cs=%b we=%b rd=%b exp legal", c, sram_cs, sram_we, sram_rd); end
      if (sram_we) begin
        n_checks++; if (int'(sram_addr) !== wr_n % DEPTH) begin n_fail++; $display("FAIL rnd_waddr got=%0d exp=%0d", sram_addr, wr_n % DEPTH); end
        wr_n++;
      end
      if (sram_rd) begin
        n_checks++; if (int'(sram_addr) !== rd_n % DEPTH) begin n_fail++; $display("FAIL rnd_raddr got=%0d exp=%0d", sram_addr, rd_n % DEPTH); end
        rd_n++;
      end
      if (out_valid && out_ready) begin
        exp_d = (q.size() != 0) ? q.pop_front() : 8'hxx;
        n_checks++; if (out_data !== exp_d) begin n_fail++; $display("FAIL rnd_data idx=%0d got=%h exp=%h", recv, out_data, exp_d); end
        recv++;
      end
      if (in_valid && in_ready) begin q.push_back(in_data); sent++; end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (recv !== 600) begin n_fail++; $display("FAIL rnd_count got=%0d exp=600", recv); end
    n_checks++; if (wr_n <= DEPTH || rd_n <= DEPTH) begin n_fail++; $display("FAIL rnd_wrap got wr=%0d rd=%0d exp both >%0d", wr_n, rd_n, DEPTH); end
    n_checks++; if (max_level > 257) begin n_fail++; $display("FAIL rnd_max_level got=%0d exp<=257", max_level); end
  endtask

  task automatic test_arb();
    do_reset();
    in_valid = 1'b1; in_data = 8'h3C; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arb_first_accept got=%b exp=1", in_ready); end
    tick();
    in_data = 8'hC3; #1;
    n_checks++; if (sram_rd !== 1'b1 || sram_we !== 1'b0 || in_ready !== 1'b0 || sram_addr !== 8'd0) begin n_fail++; $display("FAIL arb_read_wins got rd=%b we=%b ready=%b addr=%0d exp 1/0/0/0", sram_rd, sram_we, in_ready, sram_addr); end
    tick(); #1;
    n_checks++; if (sram_we !== 1'b1 || sram_rd !== 1'b0 || sram_addr !== 8'd1 || sram_wdata !== 8'hC3) begin n_fail++; $display("FAIL arb_deferred_write got we=%b rd=%b addr=%0d wdata=%h exp 1/0/1/c3", sram_we, sram_rd, sram_addr, sram_wdata); end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int accepted = 0;
    do_reset();
    in_valid = 1'b1;
    for (int c = 0; c < 40 && accepted < 10; c++) begin
      in_data = DATA_W'(8'h40 + accepted); #1;
      if (in_ready) accepted++;
      tick();
    end
    in_valid = 1'b0; #1;
    n_checks++; if (level !== 9'd10 || out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre got level=%0d valid=%b exp 10/1", level, out_valid); end
    #2 rst = 1'b1; #1;
    n_checks++; if (out_valid !== 1'b0 || level !== 9'd0 || empty !== 1'b1 || sram_cs !== 1'b0) begin n_fail++; $display("FAIL mid_reset got valid=%b level=%0d empty=%b cs=%b exp 0/0/1/0", out_valid, level, empty, sram_cs); end
    tick(); tick();
    rst = 1'b0; #1;
    n_checks++; if (level !== 9'd0) begin n_fail++; $display("FAIL mid_post_level got=%0d exp=0", level); end
    in_valid = 1'b1; in_data = 8'h99; #1;
    n_checks++; if (sram_we !== 1'b1 || sram_addr !== 8'd0) begin n_fail++; $display("FAIL mid_first_addr got we=%b addr=%0d exp 1/0", sram_we, sram_addr); end
    tick();
    in_valid = 1'b0;
    tick(); #1;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h99) begin n_fail++; $display("FAIL mid_first_out got valid=%b data=%h exp 1/99", out_valid, out_data); end
  endtask

  task automatic test_empty();
    int cs_seen = 0, valid_seen = 0;
    do_reset();
    out_ready = 1'b1; in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (sram_cs !== 1'b0) cs_seen++;
      if (out_valid !== 1'b0) valid_seen++;
      tick();
    end
    n_checks++; if (cs_seen !== 0) begin n_fail++; $display("FAIL empty_cs got %0d active cycles exp 0", cs_seen); end
    n_checks++; if (valid_seen !== 0) begin n_fail++; $display("FAIL empty_valid got %0d valid cycles exp 0", valid_seen); end
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_basic();
    test_full();
    test_random();
    test_arb();
    test_reset_mid();
    test_empty();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
